eth_frame_gen: RTL and testbench
================================

ETH_FRAME_GEN -- requirements
Module: eth_frame_gen

Interface
REQ-001 Parameter DATA_WIDTH, default 64, SHALL set the AXI-Stream data width in bits (multiple of 64).
REQ-002 Parameter KEEP_WIDTH, default DATA_WIDTH/8, SHALL set the tkeep width.
REQ-003 Parameters DST_MAC (48'h90e2ba5d8dc9), SRC_MAC (48'h001122334455) and ETHERTYPE (16'h0800) SHALL set the 14-byte frame header.
REQ-004 Parameters LEN_WIDTH, default 16, and CNT_WIDTH, default 16, SHALL set the frame-length and frame-count widths.
REQ-005 eth_clk  in  1  the single clock; sys_rst_n  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  one-cycle pulse that launches a run; stop  in  1  level that ends the run after the current frame.
REQ-007 cfg_frame_len  in  LEN_WIDTH  frame length in bytes; cfg_frame_cnt  in  CNT_WIDTH  number of frames, where 0 means continuous.
REQ-008 cfg_gap  in  8  idle cycles between frames; cfg_err_every  in  8  error-injection period, where 0 disables injection.
REQ-009 eth_rx_tvalid, eth_rx_tdata[DATA_WIDTH-1:0], eth_rx_tkeep[KEEP_WIDTH-1:0], eth_rx_tlast and eth_rx_tuser  out  are the AXI-Stream master; eth_rx_tready  in  1  is the slave ready.
REQ-010 busy  out  1  run active; done  out  1  one-cycle end-of-run pulse; frames_sent  out  CNT_WIDTH  count of completed frames.

Function
REQ-011 Byte n of a beat SHALL sit on tdata[8n+7:8n] and be qualified by tkeep[n]; frame byte 0 SHALL be beat 0, lane 0.
REQ-012 Frame bytes 0-5 SHALL be DST_MAC (MSB first), bytes 6-11 SRC_MAC (MSB first), and bytes 12-13 ETHERTYPE (MSB first).
REQ-013 Payload byte k (k>=14) of frame i (0-based within the run) SHALL be (i[7:0] + k - 14) mod 256.
REQ-014 Effective length L SHALL be max(cfg_frame_len, 60); the frame SHALL be ceil(L/KEEP_WIDTH) beats long.
REQ-015 On the last beat, tkeep SHALL be contiguous ones from bit 0 covering L mod KEEP_WIDTH bytes (all ones if 0); unused tdata bytes SHALL be 0.
REQ-016 All non-last beats SHALL have tkeep all ones; tlast SHALL be 1 only on the last beat.
REQ-017 FSM SHALL have states IDLE, SEND and GAP.
REQ-018 IDLE->SEND on start: cfg_* SHALL be latched, frames_sent cleared, and busy set; the first tvalid SHALL appear the next cycle.
REQ-019 In SEND, once tvalid=1, tvalid/tdata/tkeep/tlast/tuser SHALL be held stable until tvalid&tready; the beat advances only on that handshake.
REQ-020 On the last-beat handshake, frames_sent SHALL increment, and then: end of run -> IDLE; cfg_gap=0 -> next frame's beat 0 presented the following cycle; otherwise -> GAP.
REQ-021 GAP SHALL hold tvalid=0 for exactly cfg_gap cycles, then return to SEND.
REQ-022 The run SHALL end after frame cfg_frame_cnt, or, if stop was sampled high at any time during the current frame or gap, after the current frame completes; a gap in progress when the run ends SHALL be abandoned.
REQ-023 On entry to IDLE, done SHALL pulse for 1 cycle and busy SHALL drop in the same cycle.
REQ-024 start while busy SHALL be ignored; cfg_* changes while busy SHALL have no effect.
REQ-025 start with cfg_frame_cnt=0 SHALL run continuously; frames_sent SHALL wrap modulo 2^CNT_WIDTH.
REQ-026 tuser SHALL be 1 only on the last beat of frame i where cfg_err_every!=0 and (i+1) mod cfg_err_every == 0; otherwise 0.
REQ-027 start and stop in the same IDLE cycle SHALL send exactly one frame.

Reset
REQ-028 sys_rst_n=0 SHALL immediately force state=IDLE, tvalid=0, tlast=0, tuser=0, tdata=0, tkeep=0, busy=0, done=0 and frames_sent=0, including mid-frame; no partial frame SHALL resume after reset.

Verification
REQ-029 DATA_WIDTH=64, len=60, cnt=1, tready=1 -> 8 beats; beat0 tdata=64'h1100c98d5dbae290; beat7 tkeep=8'h0F, tlast=1; done 1 cycle after beat7.
REQ-030 len=20 -> clamped to 60 (8 beats); len=64 -> 8 beats with final tkeep=8'hFF; len=65 -> 9 beats with final tkeep=8'h01.
REQ-031 tready toggled pseudo-randomly -> data stable while stalled; no beat lost or duplicated; payload per REQ-013 for frames 0-3.
REQ-032 cnt=3, gap=5 -> exactly 5 tvalid=0 cycles between frames; gap=0 -> tvalid continuous across all 3 frames; frames_sent=3.
REQ-033 cnt=0, err_every=2, stop raised during frame 4 -> tuser only on last beats of frames 1 and 3; run ends after frame 4 with frames_sent=5.
REQ-034 sys_rst_n low mid-beat during frame 1 -> outputs cleared the same cycle; next start -> frame 0 restarts from byte 0.

Source files
------------

// File: rtl/eth_frame_gen_if.sv
// AXI-Stream bus carrying generated Ethernet frames from the generator to its sink.
// The master drives the beat fields; the slave returns tready.
interface eth_frame_gen_if #(
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8
);
  logic                  tvalid;
  logic                  tready;
  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic                  tlast;
  logic                  tuser;

  modport master (output tvalid, tdata, tkeep, tlast, tuser, input tready);
  modport slave  (input tvalid, tdata, tkeep, tlast, tuser, output tready);
endinterface

// File: rtl/eth_frame_gen.sv
// Ethernet test-frame generator: fixed 14-byte header plus counting payload, with gaps and tuser error marking.
// First beat one cycle after start; a presented beat is held until tvalid&tready, stalls never drop or repeat beats.
module eth_frame_gen #(
  parameter int          DATA_WIDTH = 64,
  parameter int          KEEP_WIDTH = DATA_WIDTH / 8,
  parameter logic [47:0] DST_MAC    = 48'h90e2ba5d8dc9,
  parameter logic [47:0] SRC_MAC    = 48'h001122334455,
  parameter logic [15:0] ETHERTYPE  = 16'h0800,
  parameter int          LEN_WIDTH  = 16,
  parameter int          CNT_WIDTH  = 16
) (
  input  logic                 eth_clk,
  input  logic                 sys_rst_n,
  input  logic                 start,
  input  logic                 stop,
  input  logic [LEN_WIDTH-1:0] cfg_frame_len,
  input  logic [CNT_WIDTH-1:0] cfg_frame_cnt,
  input  logic [7:0]           cfg_gap,
  input  logic [7:0]           cfg_err_every,
  eth_frame_gen_if.master      eth_rx,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_WIDTH-1:0] frames_sent
);

  localparam logic [111:0]          HDR     = {DST_MAC, SRC_MAC, ETHERTYPE};
  localparam logic [LEN_WIDTH-1:0]  MIN_LEN = LEN_WIDTH'(60);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [KEEP_WIDTH-1:0] keep;
    logic                  last;
    logic                  user;
  } beat_t;

  typedef struct packed {
    logic [LEN_WIDTH-1:0] len;
    logic [CNT_WIDTH-1:0] cnt;
    logic [7:0]           gap;
    logic [7:0]           err_every;
  } cfg_t;

  state_t               state, state_nxt;
  cfg_t                 cfg_q;
  beat_t                out_q, gen;
  logic                 vld_q;
  logic [LEN_WIDTH-1:0] beat_cnt;
  logic [7:0]           frame_lo;
  logic [7:0]           err_ctr;
  logic [7:0]           err_nxt;
  logic [7:0]           gap_ctr;
  logic                 stop_seen;

  logic                 hs, last_hs, run_end;
  logic [LEN_WIDTH-1:0] len_in;
  logic                 load, clear;
  logic [LEN_WIDTH-1:0] gen_beat, gen_len;
  logic [7:0]           gen_frame, gen_err, gen_every;

  assign eth_rx.tvalid = vld_q;
  assign eth_rx.tdata  = out_q.data;
  assign eth_rx.tkeep  = out_q.keep;
  assign eth_rx.tlast  = out_q.last;
  assign eth_rx.tuser  = out_q.user;

  assign busy    = (state != IDLE);
  assign hs      = vld_q & eth_rx.tready;
  assign last_hs = hs & out_q.last;
  assign len_in  = (cfg_frame_len < MIN_LEN) ? MIN_LEN : cfg_frame_len;
  assign err_nxt = ((err_ctr + 8'd1) == cfg_q.err_every) ? 8'd0 : err_ctr + 8'd1;

  // stop is looked at combinationally too, so a stop in the last-beat cycle still ends the run
  assign run_end = stop | stop_seen |
                   ((cfg_q.cnt != '0) && ((frames_sent + CNT_WIDTH'(1)) == cfg_q.cnt));

  always_ff @(posedge eth_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    clear     = 1'b0;
    gen_beat  = '0;
    gen_len   = cfg_q.len;
    gen_frame = frame_lo;
    gen_err   = err_ctr;
    gen_every = cfg_q.err_every;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = SEND;
          load      = 1'b1;
          gen_len   = len_in;
          gen_frame = 8'd0;
          gen_err   = 8'd0;
          gen_every = cfg_err_every;
        end
      end
      SEND: begin
        if (last_hs) begin
          if (run_end) begin
            state_nxt = IDLE;
            clear     = 1'b1;
          end else if (cfg_q.gap == 8'd0) begin
            load      = 1'b1;
            gen_frame = frame_lo + 8'd1;
            gen_err   = err_nxt;
          end else begin
            state_nxt = GAP;
            clear     = 1'b1;
          end
        end else if (hs) begin
          load     = 1'b1;
          gen_beat = beat_cnt + LEN_WIDTH'(1);
        end
      end
      GAP: begin
        // frame_lo/err_ctr already advanced on the last handshake of the previous frame
        if (stop || stop_seen) begin
          state_nxt = IDLE;
        end else if (gap_ctr == cfg_q.gap - 8'd1) begin
          state_nxt = SEND;
          load      = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    logic [31:0] pos;
    logic [3:0]  hidx;
    gen  = '0;
    pos  = '0;
    hidx = '0;
    for (int n = 0; n < KEEP_WIDTH; n++) begin
      pos = 32'(gen_beat) * 32'(KEEP_WIDTH) + 32'(n);
      if (pos < 32'(gen_len)) begin
        gen.keep[n] = 1'b1;
        if (pos < 32'd14) begin
          hidx = 4'(32'd13 - pos);
          gen.data[8*n +: 8] = HDR[{hidx, 3'b000} +: 8];
        end else begin
          gen.data[8*n +: 8] = gen_frame + 8'(pos - 32'd14);
        end
      end
    end
    gen.last = ((32'(gen_beat) + 32'd1) * 32'(KEEP_WIDTH)) >= 32'(gen_len);
    gen.user = gen.last && (gen_every != 8'd0) && (gen_err == gen_every - 8'd1);
  end

  always_ff @(posedge eth_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      vld_q       <= 1'b0;
      out_q       <= '0;
      cfg_q       <= '0;
      beat_cnt    <= '0;
      frame_lo    <= '0;
      err_ctr     <= '0;
      gap_ctr     <= '0;
      stop_seen   <= 1'b0;
      frames_sent <= '0;
      done        <= 1'b0;
    end else begin
      done <= (state != IDLE) && (state_nxt == IDLE);

      if (load) begin
        vld_q    <= 1'b1;
        out_q    <= gen;
        beat_cnt <= gen_beat;
      end else if (clear) begin
        vld_q <= 1'b0;
        out_q <= '0;
      end

      if (state == IDLE && start) begin
        cfg_q       <= '{len: len_in, cnt: cfg_frame_cnt, gap: cfg_gap, err_every: cfg_err_every};
        frames_sent <= '0;
        frame_lo    <= '0;
        err_ctr     <= '0;
        stop_seen   <= stop;
      end else begin
        if (stop) stop_seen <= 1'b1;
        if (last_hs) begin
          frames_sent <= frames_sent + CNT_WIDTH'(1);
          frame_lo    <= frame_lo + 8'd1;
          err_ctr     <= err_nxt;
        end
      end

      gap_ctr <= (state == GAP) ? gap_ctr + 8'd1 : 8'd0;
    end
  end

endmodule

// File: tb/tb_eth_frame_gen.sv
// Directed bench for eth_frame_gen: 64-bit bus, per-scenario tasks with hand-computed expectations.
module tb_eth_frame_gen;

  logic        eth_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [15:0] cfg_frame_len = 16'd60;
  logic [15:0] cfg_frame_cnt = 16'd1;
  logic [7:0]  cfg_gap = 8'd0;
  logic [7:0]  cfg_err_every = 8'd0;
  logic        busy, done;
  logic [15:0] frames_sent;

  eth_frame_gen_if #(.DATA_WIDTH(64), .KEEP_WIDTH(8)) eth_rx ();

  eth_frame_gen #(.DATA_WIDTH(64)) dut (
    .eth_clk       (eth_clk),
    .sys_rst_n     (sys_rst_n),
    .start         (start),
    .stop          (stop),
    .cfg_frame_len (cfg_frame_len),
    .cfg_frame_cnt (cfg_frame_cnt),
    .cfg_gap       (cfg_gap),
    .cfg_err_every (cfg_err_every),
    .eth_rx        (eth_rx),
    .busy          (busy),
    .done          (done),
    .frames_sent   (frames_sent)
  );

  always #5 eth_clk = ~eth_clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit rdy_rand = 1'b0;

  logic [63:0] b_data[$];
  logic [7:0]  b_keep[$];
  logic        b_last[$];
  logic        b_user[$];
  int          b_cyc[$];
  logic        h_vld[$];
  logic        h_rdy[$];
  logic [63:0] h_data[$];
  logic [7:0]  h_keep[$];
  logic        h_last[$];
  logic        h_user[$];
  int          done_cyc[$];

  logic [7:0] hdr_tab[14] = '{8'h90, 8'he2, 8'hba, 8'h5d, 8'h8d, 8'hc9,
                              8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55,
                              8'h08, 8'h00};

  function automatic logic [7:0] exp_byte(int i, int k);
    if (k < 14) return hdr_tab[k];
    return 8'((i + k - 14) % 256);
  endfunction

  function automatic logic [63:0] exp_data(int i, int b, int len);
    logic [63:0] d = '0;
    for (int n = 0; n < 8; n++)
      if (b * 8 + n < len) d[8*n +: 8] = exp_byte(i, b * 8 + n);
    return d;
  endfunction

  function automatic logic [7:0] exp_keep(int b, int len);
    logic [7:0] k = '0;
    for (int n = 0; n < 8; n++) k[n] = (b * 8 + n < len);
    return k;
  endfunction

  task automatic clear_hist();
    b_data.delete(); b_keep.delete(); b_last.delete(); b_user.delete(); b_cyc.delete();
    h_vld.delete(); h_rdy.delete(); h_data.delete(); h_keep.delete();
    h_last.delete(); h_user.delete(); done_cyc.delete();
    cyc = 0;
  endtask

  // Sample on the falling edge, then re-drive tready just after the rising edge.
  task automatic tick();
    @(negedge eth_clk);
    cyc++;
    h_vld.push_back(eth_rx.tvalid);  h_rdy.push_back(eth_rx.tready);
    h_data.push_back(eth_rx.tdata);  h_keep.push_back(eth_rx.tkeep);
    h_last.push_back(eth_rx.tlast);  h_user.push_back(eth_rx.tuser);
    if (eth_rx.tvalid && eth_rx.tready) begin
      b_data.push_back(eth_rx.tdata); b_keep.push_back(eth_rx.tkeep);
      b_last.push_back(eth_rx.tlast); b_user.push_back(eth_rx.tuser);
      b_cyc.push_back(cyc);
    end
    if (done) done_cyc.push_back(cyc);
    @(posedge eth_clk);
    #1;
    eth_rx.tready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic launch(input int len, input int cnt, input int gap, input int err, input logic stp);
    clear_hist();
    cfg_frame_len = 16'(len);
    cfg_frame_cnt = 16'(cnt);
    cfg_gap       = 8'(gap);
    cfg_err_every = 8'(err);
    start = 1'b1;
    stop  = stp;
    tick();
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (done_cyc.size() > 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge eth_clk);
    #1;
    total++; if (eth_rx.tvalid !== 1'b0) begin bad++; $display("FAIL reset_tvalid got=%0b want=0", eth_rx.tvalid); end
    total++; if (eth_rx.tdata !== 64'h0) begin bad++; $display("FAIL reset_tdata got=%h want=0", eth_rx.tdata); end
    total++; if (eth_rx.tkeep !== 8'h0) begin bad++; $display("FAIL reset_tkeep got=%h want=0", eth_rx.tkeep); end
    total++; if ({eth_rx.tlast, eth_rx.tuser} !== 2'b00) begin bad++; $display("FAIL reset_last_user got=%b want=00", {eth_rx.tlast, eth_rx.tuser}); end
    total++; if ({busy, done} !== 2'b00) begin bad++; $display("FAIL reset_busy_done got=%b want=00", {busy, done}); end
    total++; if (frames_sent !== 16'd0) begin bad++; $display("FAIL reset_frames got=%0d want=0", frames_sent); end
    @(negedge eth_clk);
    sys_rst_n = 1'b1;
    @(posedge eth_clk);
    #1;
  endtask

  task automatic test_basic();
    bit ok;
    int nlast;
    launch(60, 1, 0, 0, 1'b0);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy got=%0b want=1", busy); end
    wait_done(100, ok);
    total++; if (!ok) begin bad++; $display("FAIL basic_timeout done=0 want=1"); end
    total++; if (b_data.size() != 8) begin bad++; $display("FAIL basic_beats got=%0d want=8", b_data.size()); end
    if (b_data.size() == 8) begin
      total++; if (b_cyc[0] != 2) begin bad++; $display("FAIL basic_first_cycle got=%0d want=2", b_cyc[0]); end
      total++; if (b_data[0] !== 64'h1100c98d5dbae290) begin bad++; $display("FAIL basic_beat0 got=%h want=1100c98d5dbae290", b_data[0]); end
      total++; if (b_data[1] !== 64'h0100000855443322) begin bad++; $display("FAIL basic_beat1 got=%h want=0100000855443322", b_data[1]); end
      total++; if (b_data[7] !== 64'h000000002d2c2b2a) begin bad++; $display("FAIL basic_beat7 got=%h want=000000002d2c2b2a", b_data[7]); end
      total++; if (b_keep[7] !== 8'h0F || b_last[7] !== 1'b1) begin bad++; $display("FAIL basic_tail keep=%h last=%0b want keep=0f last=1", b_keep[7], b_last[7]); end
      nlast = 0;
      for (int j = 0; j < 7; j++) if (b_last[j] !== 1'b0 || b_keep[j] !== 8'hFF) nlast++;
      total++; if (nlast != 0) begin bad++; $display("FAIL basic_midbeats bad=%0d want=0", nlast); end
      total++; if (done_cyc[0] != b_cyc[7] + 1) begin bad++; $display("FAIL basic_done_cycle got=%0d want=%0d", done_cyc[0], b_cyc[7] + 1); end
    end
    total++; if (frames_sent !== 16'd1 || busy !== 1'b0) begin bad++; $display("FAIL basic_end frames=%0d busy=%0b want 1/0", frames_sent, busy); end
    repeat (3) tick();
    total++; if (done_cyc.size() != 1) begin bad++; $display("FAIL basic_done_width got=%0d want=1", done_cyc.size()); end
  endtask

  task automatic test_lengths();
    int          lens[3]  = '{20, 64, 65};
    int          beats[3] = '{8, 8, 9};
    logic [7:0]  keeps[3] = '{8'h0F, 8'hFF, 8'h01};
    logic [63:0] lastd[3] = '{64'h000000002d2c2b2a, 64'h31302f2e2d2c2b2a, 64'h0000000000000032};
    bit ok;
    for (int t = 0; t < 3; t++) begin
      launch(lens[t], 1, 0, 0, 1'b0);
      wait_done(100, ok);
      total++; if (!ok || b_data.size() != beats[t]) begin bad++; $display("FAIL len%0d_beats got=%0d want=%0d", lens[t], b_data.size(), beats[t]); end
      if (b_data.size() == beats[t]) begin
        total++; if (b_keep[beats[t]-1] !== keeps[t]) begin bad++; $display("FAIL len%0d_keep got=%h want=%h", lens[t], b_keep[beats[t]-1], keeps[t]); end
        total++; if (b_data[beats[t]-1] !== lastd[t]) begin bad++; $display("FAIL len%0d_data got=%h want=%h", lens[t], b_data[beats[t]-1], lastd[t]); end
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int stalls;
    rdy_rand = 1'b1;
    launch(70, 4, 2, 0, 1'b0);
    wait_done(2000, ok);
    rdy_rand = 1'b0;
    total++; if (!ok || b_data.size() != 36) begin bad++; $display("FAIL bp_beats got=%0d want=36", b_data.size()); end
    if (b_data.size() == 36) begin
      for (int j = 0; j < 36; j++) begin
        total++;
        if (b_data[j] !== exp_data(j / 9, j % 9, 70) || b_keep[j] !== exp_keep(j % 9, 70) ||
            b_last[j] !== (j % 9 == 8)) begin
          bad++;
          $display("FAIL bp_beat%0d data=%h keep=%h last=%0b want data=%h keep=%h last=%0b", j,
                   b_data[j], b_keep[j], b_last[j], exp_data(j / 9, j % 9, 70), exp_keep(j % 9, 70), (j % 9 == 8));
        end
      end
    end
    stalls = 0;
    for (int t = 0; t + 1 < h_vld.size(); t++) begin
      if (h_vld[t] && !h_rdy[t]) begin
        stalls++;
        total++;
        if (h_vld[t+1] !== 1'b1 || h_data[t+1] !== h_data[t] || h_keep[t+1] !== h_keep[t] ||
            h_last[t+1] !== h_last[t] || h_user[t+1] !== h_user[t]) begin
          bad++;
          $display("FAIL bp_stable cyc=%0d data=%h->%h vld=%0b want held", t + 1, h_data[t], h_data[t+1], h_vld[t+1]);
        end
      end
    end
    total++; if (frames_sent !== 16'd4) begin bad++; $display("FAIL bp_frames got=%0d want=4", frames_sent); end
  endtask

  task automatic test_gap();
    int gaps[2] = '{5, 0};
    bit ok;
    for (int t = 0; t < 2; t++) begin
      launch(60, 3, gaps[t], 0, 1'b0);
      wait_done(200, ok);
      total++; if (!ok || b_data.size() != 24) begin bad++; $display("FAIL gap%0d_beats got=%0d want=24", gaps[t], b_data.size()); end
      if (b_data.size() == 24) begin
        total++; if (b_cyc[8] - b_cyc[7] - 1 != gaps[t]) begin bad++; $display("FAIL gap%0d_first got=%0d want=%0d", gaps[t], b_cyc[8] - b_cyc[7] - 1, gaps[t]); end
        total++; if (b_cyc[16] - b_cyc[15] - 1 != gaps[t]) begin bad++; $display("FAIL gap%0d_second got=%0d want=%0d", gaps[t], b_cyc[16] - b_cyc[15] - 1, gaps[t]); end
      end
      total++; if (frames_sent !== 16'd3) begin bad++; $display("FAIL gap%0d_frames got=%0d want=3", gaps[t], frames_sent); end
    end
  endtask

  task automatic test_err_stop();
    bit ok;
    bit want;
    launch(60, 0, 0, 2, 1'b0);
    for (int i = 0; i < 200 && b_data.size() < 35; i++) tick();
    stop = 1'b1;
    wait_done(100, ok);
    stop = 1'b0;
    total++; if (!ok || b_data.size() != 40) begin bad++; $display("FAIL err_beats got=%0d want=40", b_data.size()); end
    if (b_data.size() == 40) begin
      for (int j = 0; j < 40; j++) begin
        want = (j % 8 == 7) && (j / 8 == 1 || j / 8 == 3);
        total++; if (b_user[j] !== want) begin bad++; $display("FAIL err_tuser beat=%0d got=%0b want=%0b", j, b_user[j], want); end
      end
      total++; if (b_data[34] !== 64'h0d0c0b0a09080706) begin bad++; $display("FAIL err_f4_payload got=%h want=0d0c0b0a09080706", b_data[34]); end
    end
    total++; if (frames_sent !== 16'd5) begin bad++; $display("FAIL err_frames got=%0d want=5", frames_sent); end
  endtask

  task automatic test_mid_reset();
    bit ok;
    int vcount;
    launch(60, 2, 0, 0, 1'b0);
    for (int i = 0; i < 100 && b_data.size() < 11; i++) tick();
    sys_rst_n = 1'b0;
    #2;
    total++; if (eth_rx.tvalid !== 1'b0 || eth_rx.tdata !== 64'h0 || eth_rx.tkeep !== 8'h0) begin bad++; $display("FAIL mrst_outputs vld=%0b data=%h keep=%h want 0", eth_rx.tvalid, eth_rx.tdata, eth_rx.tkeep); end
    total++; if (busy !== 1'b0 || frames_sent !== 16'd0) begin bad++; $display("FAIL mrst_state busy=%0b frames=%0d want 0/0", busy, frames_sent); end
    @(negedge eth_clk);
    sys_rst_n = 1'b1;
    @(posedge eth_clk);
    #1;
    clear_hist();
    repeat (4) tick();
    vcount = 0;
    foreach (h_vld[t]) if (h_vld[t] !== 1'b0) vcount++;
    total++; if (vcount != 0) begin bad++; $display("FAIL mrst_no_resume got=%0d want=0", vcount); end
    launch(60, 1, 0, 0, 1'b0);
    wait_done(100, ok);
    total++; if (!ok || b_data.size() != 8) begin bad++; $display("FAIL mrst_beats got=%0d want=8", b_data.size()); end
    if (b_data.size() == 8) begin
      total++; if (b_data[0] !== 64'h1100c98d5dbae290 || b_data[1] !== 64'h0100000855443322) begin bad++; $display("FAIL mrst_restart b0=%h b1=%h", b_data[0], b_data[1]); end
    end
    total++; if (frames_sent !== 16'd1) begin bad++; $display("FAIL mrst_frames got=%0d want=1", frames_sent); end
  endtask

  task automatic test_busy_ignore();
    bit ok;
    launch(60, 2, 0, 0, 1'b0);
    repeat (4) tick();
    cfg_frame_len = 16'd100;
    cfg_frame_cnt = 16'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(200, ok);
    total++; if (!ok || b_data.size() != 16) begin bad++; $display("FAIL busy_beats got=%0d want=16", b_data.size()); end
    if (b_data.size() == 16) begin
      total++; if (b_keep[15] !== 8'h0F) begin bad++; $display("FAIL busy_keep got=%h want=0f", b_keep[15]); end
    end
    total++; if (frames_sent !== 16'd2) begin bad++; $display("FAIL busy_frames got=%0d want=2", frames_sent); end
  endtask

  task automatic test_start_stop();
    bit ok;
    launch(60, 0, 0, 0, 1'b1);
    wait_done(100, ok);
    total++; if (!ok || b_data.size() != 8) begin bad++; $display("FAIL ss_beats got=%0d want=8", b_data.size()); end
    total++; if (frames_sent !== 16'd1) begin bad++; $display("FAIL ss_frames got=%0d want=1", frames_sent); end
  endtask

  initial begin
    eth_rx.tready = 1'b1;
    test_reset();
    test_basic();
    test_lengths();
    test_backpressure();
    test_gap();
    test_err_stop();
    test_mid_reset();
    test_busy_ignore();
    test_start_stop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
